// File: rtl/metronome_axil_regs.sv
// AXI4-Lite register slave for the metronome: CTRL/PERIOD/PULSE_W/STATUS plus the beat generator.
// Optional macro METRONOME_IRQ_EN adds irq_o and the CTRL[2] IRQ_MASK bit.
module metronome_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            beat_o
`ifdef METRONOME_IRQ_EN
   ,
   output logic                            irq_o
`endif
);

   logic        r_awready, r_bvalid, r_arready, r_rvalid;
   logic [31:0] r_rdata;
   logic        r_en, r_clr, r_mask, r_irq, r_beat;
   logic [31:0] r_period, r_pulse_w, r_beats, r_cnt;

   logic        w_wr_go, w_wr_en, w_rd_go, w_rd_en, w_per_wr, w_run, w_wrap;
   logic [1:0]  w_wr_idx, w_rd_idx;
   logic [31:0] w_rd_val, w_ctrl_rd, w_ctrl_new;
   logic        w_unused;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      return res;
   endfunction

   assign w_wr_idx   = S_AXI_AWADDR[3:2];
   assign w_rd_idx   = S_AXI_ARADDR[3:2];
   assign w_wr_go    = S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid && !r_awready;
   assign w_wr_en    = r_awready && S_AXI_AWVALID && S_AXI_WVALID;
   assign w_rd_go    = S_AXI_ARVALID && !r_rvalid && !r_arready;
   assign w_rd_en    = r_arready && S_AXI_ARVALID;
   assign w_per_wr   = w_wr_en && (w_wr_idx == 2'd1);
   // CLR is write-only, so it never shows up in the readable image
   assign w_ctrl_rd  = {29'd0, r_mask, 1'b0, r_en};
   assign w_ctrl_new = f_merge(w_ctrl_rd, S_AXI_WDATA, S_AXI_WSTRB);

   always_comb begin
      w_rd_val = 32'd0;
      case (w_rd_idx)
         2'd0: w_rd_val = w_ctrl_rd;
         2'd1: w_rd_val = r_period;
         2'd2: w_rd_val = r_pulse_w;
         2'd3: w_rd_val = r_beats;
      endcase
   end

   // Bus handshakes: one write and one read outstanding at most
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= 32'd0;
      end else begin
         r_awready <= w_wr_go;
         if (w_wr_en)                      r_bvalid <= 1'b1;
         else if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
         r_arready <= w_rd_go;
         if (w_rd_en) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_val;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_en      <= 1'b0;
         r_clr     <= 1'b0;
         r_mask    <= 1'b0;
         r_period  <= 32'd0;
         r_pulse_w <= 32'd0;
      end else begin
         r_clr <= 1'b0;
         if (w_wr_en) begin
            case (w_wr_idx)
               2'd0: begin
                  r_en  <= w_ctrl_new[0];
                  r_clr <= w_ctrl_new[1];
`ifdef METRONOME_IRQ_EN
                  r_mask <= w_ctrl_new[2];
`endif
               end
               2'd1: r_period  <= f_merge(r_period, S_AXI_WDATA, S_AXI_WSTRB);
               2'd2: r_pulse_w <= f_merge(r_pulse_w, S_AXI_WDATA, S_AXI_WSTRB);
               default: ;
            endcase
         end
      end
   end

   // A wrap coinciding with CLR or a PERIOD write is discarded
   assign w_run  = r_en && (r_period != 32'd0);
   assign w_wrap = w_run && (r_cnt == r_period - 32'd1) && !r_clr && !w_per_wr;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_cnt   <= 32'd0;
         r_beats <= 32'd0;
         r_beat  <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         if (r_clr || !w_run || w_per_wr || w_wrap) r_cnt <= 32'd0;
         else                                       r_cnt <= r_cnt + 32'd1;
         if (r_clr)       r_beats <= 32'd0;
         else if (w_wrap) r_beats <= r_beats + 32'd1;
         r_beat <= w_run && (r_cnt < r_pulse_w);
         if (w_wrap && r_mask)                       r_irq <= 1'b1;
         else if (w_wr_en && (w_wr_idx == 2'd3))     r_irq <= 1'b0;
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_awready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = 2'b00;
   assign beat_o        = r_beat;
`ifdef METRONOME_IRQ_EN
   assign irq_o         = r_irq;
`endif

endmodule
